// File: rtl/lna_pwr_pkg.sv
// lna_pwr_pkg: channel state encoding, fault codes and grant-holding helper shared by the LNA bias sequencer
package lna_pwr_pkg;
  typedef enum logic [3:0] {
    ST_OFF,
    ST_WAIT_GRANT,
    ST_NEG_RAMP,
    ST_NEG_SETTLE,
    ST_POS_RAMP,
    ST_ON,
    ST_POS_DOWN,
    ST_NEG_DOWN,
    ST_FAULT
  } ch_state_t;
  localparam logic [1:0] FAULT_NONE = 2'd0;
  localparam logic [1:0] FAULT_VMINUS_TO = 2'd1;
  localparam logic [1:0] FAULT_VPLUS_TO = 2'd2;
  localparam logic [1:0] FAULT_RAIL_LOSS = 2'd3;
  function automatic logic holds_grant(input ch_state_t s);
    return s inside {ST_NEG_RAMP, ST_NEG_SETTLE, ST_POS_RAMP};
  endfunction
endpackage

// File: rtl/lna_channel_fsm.sv
// lna_channel_fsm: one LNA bias channel (enable/rail-good in, grant_in; rail enables, ready, latched fault + code, req_out/hold_out out)
module lna_channel_fsm
  import lna_pwr_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int SETTLE_CYCLES = 1000,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       vminus_good,
  input  logic       vplus_good,
  input  logic       grant_in,
  output logic       req_out,
  output logic       hold_out,
  output logic       vminus_en,
  output logic       vplus_en,
  output logic       ready,
  output logic       fault,
  output logic [1:0] fault_code
);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  ch_state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_sat;
  logic settle_done, timed_out, flt_n;
  logic [1:0] code_n, trip;
  assign cnt_sat = (cnt == '1) ? cnt : cnt + CNT_W'(1);
  assign settle_done = cnt == SETTLE_LAST;
  assign timed_out = cnt == TIMEOUT_LAST;
  assign req_out = state == ST_WAIT_GRANT;
  assign hold_out = holds_grant(state);
  always_comb begin
    state_n = state;
    flt_n = fault;
    code_n = fault_code;
    trip = FAULT_NONE;
    case (state)
      ST_OFF: state_n = enable ? ST_WAIT_GRANT : ST_OFF;
      ST_WAIT_GRANT: state_n = !enable ? ST_OFF : grant_in ? ST_NEG_RAMP : ST_WAIT_GRANT;
      ST_NEG_RAMP: begin
        trip = (!vminus_good && timed_out) ? FAULT_VMINUS_TO : FAULT_NONE;
        state_n = !enable ? ST_POS_DOWN : vminus_good ? ST_NEG_SETTLE : ST_NEG_RAMP;
      end
      ST_NEG_SETTLE: begin
        trip = !vminus_good ? FAULT_RAIL_LOSS : FAULT_NONE;
        state_n = !enable ? ST_POS_DOWN : settle_done ? ST_POS_RAMP : ST_NEG_SETTLE;
      end
      ST_POS_RAMP: begin
        trip = !vminus_good ? FAULT_RAIL_LOSS : (!vplus_good && timed_out) ? FAULT_VPLUS_TO : FAULT_NONE;
        state_n = !enable ? ST_POS_DOWN : vplus_good ? ST_ON : ST_POS_RAMP;
      end
      ST_ON: begin
        trip = (!vminus_good || !vplus_good) ? FAULT_RAIL_LOSS : FAULT_NONE;
        state_n = !enable ? ST_POS_DOWN : ST_ON;
      end
      ST_POS_DOWN: state_n = settle_done ? ST_NEG_DOWN : ST_POS_DOWN;
      ST_NEG_DOWN: state_n = !settle_done ? ST_NEG_DOWN : fault ? ST_FAULT : ST_OFF;
      ST_FAULT: begin
        state_n = enable ? ST_FAULT : ST_OFF;
        flt_n = enable;
        code_n = enable ? fault_code : FAULT_NONE;
      end
      default: state_n = ST_OFF;
    endcase
    if (trip != FAULT_NONE) begin
      state_n = ST_POS_DOWN;
      flt_n = 1'b1;
      code_n = trip;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_OFF;
      cnt <= '0;
      vminus_en <= 1'b0;
      vplus_en <= 1'b0;
      ready <= 1'b0;
      fault <= 1'b0;
      fault_code <= FAULT_NONE;
    end else begin
      state <= state_n;
      cnt <= (state_n != state) ? '0 : cnt_sat;
      vminus_en <= state_n inside {ST_NEG_RAMP, ST_NEG_SETTLE, ST_POS_RAMP, ST_ON, ST_POS_DOWN};
      vplus_en <= state_n inside {ST_POS_RAMP, ST_ON};
      ready <= state_n == ST_ON;
      fault <= flt_n;
      fault_code <= code_n;
    end
  end
endmodule

// File: rtl/lna_power_sequencer.sv
// lna_power_sequencer: CHANNELS LNA bias sequencers (Enable/VminusGood/VplusGood in; VminusEn/VplusEn/Ready/Fault/FaultCode/Busy out) sharing one ramp grant
module lna_power_sequencer
  import lna_pwr_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int CNT_W = 16,
  parameter int SETTLE_CYCLES = 1000,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                  Clock100Mhz,
  input  logic                  Reset,
  input  logic [CHANNELS-1:0]   Enable,
  input  logic [CHANNELS-1:0]   VminusGood,
  input  logic [CHANNELS-1:0]   VplusGood,
  output logic [CHANNELS-1:0]   VminusEn,
  output logic [CHANNELS-1:0]   VplusEn,
  output logic [CHANNELS-1:0]   Ready,
  output logic [CHANNELS-1:0]   Fault,
  output logic [2*CHANNELS-1:0] FaultCode,
  output logic                  Busy
);
  logic [CHANNELS-1:0] req, hold, grant;
  if (CHANNELS < 1 || CHANNELS > 16 || (SETTLE_CYCLES >> CNT_W) != 0 || (TIMEOUT_CYCLES >> CNT_W) != 0) begin : g_bad_param
    $error("lna_power_sequencer: CHANNELS must be 1..16 and SETTLE/TIMEOUT must fit in CNT_W bits");
  end
  assign grant = (|hold) ? '0 : req & (~req + CHANNELS'(1));
  assign Busy = (|hold) | (|grant);
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    lna_channel_fsm #(
      .CNT_W(CNT_W),
      .SETTLE_CYCLES(SETTLE_CYCLES),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_ch (
      .clk(Clock100Mhz),
      .rst(Reset),
      .enable(Enable[i]),
      .vminus_good(VminusGood[i]),
      .vplus_good(VplusGood[i]),
      .grant_in(grant[i]),
      .req_out(req[i]),
      .hold_out(hold[i]),
      .vminus_en(VminusEn[i]),
      .vplus_en(VplusEn[i]),
      .ready(Ready[i]),
      .fault(Fault[i]),
      .fault_code(FaultCode[2*i +: 2])
    );
  end
endmodule

// File: tb/tb_lna_power_sequencer.sv
// tb_lna_power_sequencer: directed scenarios with a scoreboard of expected output-change events checked by an independent monitor
module tb_lna_power_sequencer;
  localparam int VM_DLY = 3;
  localparam int VP_DLY = 2;
  typedef struct {
    int c;
    logic [24:0] s;
  } ev_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] enable = '0;
  logic [3:0] vminus_good, vplus_good, vminus_en, vplus_en, ready, fault;
  logic [7:0] fault_code;
  logic busy;
  int cyc = 0;
  int vm_cnt[4];
  int vp_cnt[4];
  logic [3:0] vm_kill = '0;
  int n_tests = 0;
  int n_fail = 0;
  bit done = 1'b0;
  ev_t sb[$];
  logic [3:0] e_vm = '0, e_vp = '0, e_rdy = '0, e_flt = '0;
  logic [7:0] e_code = '0;
  logic e_busy = 1'b0;
  lna_power_sequencer #(
    .CHANNELS(4),
    .CNT_W(16),
    .SETTLE_CYCLES(8),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .Clock100Mhz(clk),
    .Reset(reset),
    .Enable(enable),
    .VminusGood(vminus_good),
    .VplusGood(vplus_good),
    .VminusEn(vminus_en),
    .VplusEn(vplus_en),
    .Ready(ready),
    .Fault(fault),
    .FaultCode(fault_code),
    .Busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      vminus_good[i] = vminus_en[i] && (vm_cnt[i] > VM_DLY) && !vm_kill[i];
      vplus_good[i] = vplus_en[i] && (vp_cnt[i] > VP_DLY);
    end
  end
  initial forever begin
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      vm_cnt[i] = (vminus_en[i] === 1'b1) ? vm_cnt[i] + 1 : 0;
      vp_cnt[i] = (vplus_en[i] === 1'b1) ? vp_cnt[i] + 1 : 0;
    end
  end
  task automatic wait_to(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic push(input int n);
    sb.push_back('{c: n, s: {e_vm, e_vp, e_rdy, e_flt, e_code, e_busy}});
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  initial begin : stim
    int t;
    wait_to(4);
    reset = 1'b0;
    t = cyc;
    enable[0] = 1'b1;
    e_busy = 1'b1; push(t + 1);
    e_vm[0] = 1'b1; push(t + 2);
    e_vp[0] = 1'b1; push(t + 14);
    e_rdy[0] = 1'b1; e_busy = 1'b0; push(t + 17);
    wait_to(t + 20);
    t = cyc;
    enable[2:1] = 2'b11;
    e_busy = 1'b1; push(t + 1);
    e_vm[1] = 1'b1; push(t + 2);
    e_vp[1] = 1'b1; push(t + 14);
    e_rdy[1] = 1'b1; push(t + 17);
    e_vm[2] = 1'b1; push(t + 18);
    e_vp[2] = 1'b1; push(t + 30);
    e_rdy[2] = 1'b1; e_busy = 1'b0; push(t + 33);
    wait_to(t + 36);
    t = cyc;
    enable[0] = 1'b0;
    e_vp[0] = 1'b0; e_rdy[0] = 1'b0; push(t + 1);
    e_vm[0] = 1'b0; push(t + 9);
    wait_to(t + 4);
    enable[0] = 1'b1;
    wait_to(t + 6);
    enable[0] = 1'b0;
    wait_to(t + 12);
    enable[0] = 1'b1;
    e_busy = 1'b1; push(t + 18);
    e_vm[0] = 1'b1; push(t + 19);
    e_vp[0] = 1'b1; push(t + 31);
    e_rdy[0] = 1'b1; e_busy = 1'b0; push(t + 34);
    wait_to(t + 37);
    t = cyc;
    enable[3] = 1'b1;
    vm_kill[3] = 1'b1;
    e_busy = 1'b1; push(t + 1);
    e_vm[3] = 1'b1; push(t + 2);
    e_flt[3] = 1'b1; e_code[7:6] = 2'd1; e_busy = 1'b0; push(t + 18);
    e_vm[3] = 1'b0; push(t + 26);
    wait_to(t + 40);
    enable[3] = 1'b0;
    e_flt[3] = 1'b0; e_code[7:6] = 2'd0; push(t + 41);
    wait_to(t + 44);
    vm_kill[3] = 1'b0;
    t = cyc;
    vm_kill[0] = 1'b1;
    e_flt[0] = 1'b1; e_code[1:0] = 2'd3; e_vp[0] = 1'b0; e_rdy[0] = 1'b0; push(t + 1);
    e_vm[0] = 1'b0; push(t + 9);
    wait_to(t + 1);
    vm_kill[0] = 1'b0;
    wait_to(t + 20);
    enable[0] = 1'b0;
    e_flt[0] = 1'b0; e_code[1:0] = 2'd0; push(t + 21);
    wait_to(t + 24);
    t = cyc;
    enable[0] = 1'b1;
    e_busy = 1'b1; push(t + 1);
    e_vm[0] = 1'b1; push(t + 2);
    e_vp[0] = 1'b1; push(t + 14);
    wait_to(t + 15);
    reset = 1'b1;
    enable[2:1] = 2'b00;
    e_vm = '0; e_vp = '0; e_rdy = '0; e_flt = '0; e_code = '0; e_busy = 1'b0; push(t + 16);
    wait_to(t + 17);
    reset = 1'b0;
    e_busy = 1'b1; push(t + 18);
    e_vm[0] = 1'b1; push(t + 19);
    e_vp[0] = 1'b1; push(t + 31);
    e_rdy[0] = 1'b1; e_busy = 1'b0; push(t + 34);
    wait_to(t + 38);
    done = 1'b1;
  end
  initial begin : mon
    logic [24:0] snap, prev;
    ev_t e;
    repeat (4) @(negedge clk);
    chk("reset_vminus_en", 32'(vminus_en), 32'd0);
    chk("reset_vplus_en", 32'(vplus_en), 32'd0);
    chk("reset_ready", 32'(ready), 32'd0);
    chk("reset_fault", 32'(fault), 32'd0);
    chk("reset_fault_code", 32'(fault_code), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    prev = '0;
    forever begin
      @(negedge clk);
      if (done) break;
      snap = {vminus_en, vplus_en, ready, fault, fault_code, busy};
      if (snap !== prev) begin
        if (sb.size() == 0) begin
          chk("unexpected_change", 32'(snap), 32'(prev));
        end else begin
          e = sb.pop_front();
          chk("event_cycle", cyc, e.c);
          chk("event_outputs", 32'(snap), 32'(e.s));
        end
      end
      prev = snap;
    end
    while (sb.size() != 0) begin
      e = sb.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL missing_event: got no change, expected outputs %0h at cycle %0d", e.s, e.c);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
  initial begin
    #50000;
    $display("FAIL watchdog: run still active at cycle %0d, expected finish near cycle 210", cyc);
    $fatal(1, "watchdog expired");
  end
endmodule
